pwm_duty_meter: RTL and testbench
=================================

// Module: pwm_duty_meter
// PURPOSE
//  Downstream monitor for the 8-bit PWM generator. Samples the generator's
//  pwm_out on this block's pwm_in. Measures high time and period in clock
//  cycles, one measurement per PWM period. Flags a line stuck high or low
//  when no edge arrives in time (duty 0 / full-on). Used for closed-loop
//  duty checking and fault reporting.
// PARAMETERS
//  CW       16      width of the high_cnt / period_cnt counters and outputs
//  TIMEOUT  1024    clocks without a rising edge before a stuck flag is raised
//  SYNC_EN  1       1: 2-flop synchronizer on pwm_in; 0: pwm_in is already in the clk domain
// PORTS
//  clk         in   1    system clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  pwm_in      in   1    PWM signal under measurement
//  high_cnt    out  CW   high time of the last complete period, in clocks
//  period_cnt  out  CW   rising-to-rising period of the last complete period, in clocks
//  meas_valid  out  1    1-cycle strobe: high_cnt and period_cnt just updated
//  stuck_high  out  1    level: no rising edge for TIMEOUT clocks, line high
//  stuck_low   out  1    level: no rising edge for TIMEOUT clocks, line low
// BEHAVIOUR
//  - Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n).
//  - Reset values: all outputs 0, state IDLE, counters 0, sync and edge flops 0.
//  - Input path: pwm_in -> sync (2 flops when SYNC_EN=1) -> s.
//    The prev flop holds s delayed by one clock.
//    rise = s & ~prev; fall = ~s & prev.
//    Edge detection lags the pin by 3 clocks (SYNC_EN=1) or 1 clock (SYNC_EN=0).
//    The lag is identical on both edges, so the measured values are unaffected.
//  - Counters: per_c and hi_c, each CW bits, saturating at all-ones (no wrap).
//  - FSM states:
//    IDLE   : counters held at 0. On rise -> MEAS; per_c <= 1, hi_c <= 1.
//    MEAS   : per_c increments every clock; hi_c increments while s=1.
//             On fall: hi_c freezes until the next rise.
//             On rise: period_cnt <= per_c, high_cnt <= hi_c, meas_valid <= 1 next cycle;
//             per_c <= 1, hi_c <= 1; stuck_* <= 0.
//             If per_c == TIMEOUT-1 with no rise -> STUCK.
//    STUCK  : stuck_high <= s, stuck_low <= ~s (track s each clock).
//             period_cnt and high_cnt hold their last values.
//             On rise -> MEAS as from IDLE; stuck_* clear on that cycle.
//             No meas_valid is issued for the partial period.
//  - IDLE also times out: a rise-free TIMEOUT window -> STUCK. This covers a
//    constant line from reset.
//  - The first rise after reset or after STUCK only arms the FSM.
//    The first meas_valid comes at the second rise.
//  - Simultaneous rise and timeout: rise wins; the measurement is taken and
//    stuck_* stay 0.
//  - Values: high_cnt <= period_cnt always. Both are edge-to-edge clock counts.
//    An ideal 256-clock PWM with duty D gives period 256 and high D.
//  - rst_n asserted mid-period: the partial measurement is discarded and
//    everything returns to reset values.
//  - TIMEOUT must exceed the longest legal period; this is not checked in RTL.
// STRUCTURE
//  - pwm_defs.vh: FSM state encodings (IDLE=2'd0, MEAS=2'd1, STUCK=2'd2) and
//    default CW/TIMEOUT localparams, shared with the generator bench.
//  - Sub-module pwm_sync_edge: optional 2-flop synchronizer, prev flop, and the
//    rise/fall outputs. Reused by other edge-driven monitors.
//  - Top level: FSM, the two saturating counters, output registers.
// TESTING
//  Drive pwm_in from the generator at a 10 ns clk.
//  1. Generator duty 10 -> meas_valid once per 256 clocks; high_cnt=10, period_cnt=256.
//  2. Duty changed 10 -> 255 mid-period -> one transitional sample, then high_cnt=255,
//     period_cnt=256 steady.
//  3. Duty 0 (line low) -> after TIMEOUT=1024 clocks: stuck_low=1, stuck_high=0,
//     no meas_valid, last counts held.
//  4. Line forced high from reset -> stuck_high=1 at 1024 clocks.
//     Release to duty 128 -> stuck_high clears on the first rise; first
//     meas_valid at the next rise reports 128/256.
//  5. rst_n pulsed low for 3 clocks mid-high-phase -> outputs 0 immediately;
//     the next meas_valid comes two rises later with correct values.
//  6. Glitch-free direct drive with SYNC_EN=0: high 3 / low 5 pattern ->
//     high_cnt=3, period_cnt=8.
//     A 1-clock pulse train gives high_cnt=1, period_cnt=2.

Source files
------------

// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: FSM state encoding, default
// sizing and the timeout timer width helper.
package pwm_duty_meter_pkg;

    localparam int CW_DEF      = 16;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEAS  = 2'd1,
        ST_STUCK = 2'd2
    } meter_state_e;

    // Bits needed to hold TIMEOUT-1 in the idle down-counter.
    function automatic int tmr_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Bundle between the PWM line under test and the duty meter results.
// master = meter side (samples pwm_in, drives results),
// slave  = line owner / result consumer.
interface pwm_duty_meter_if #(
    parameter int CW = 16
);
    logic          pwm_in;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          stuck_high;
    logic          stuck_low;

    modport master (
        input  pwm_in,
        output high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
    );

    modport slave (
        output pwm_in,
        input  high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
    );
endinterface

// File: rtl/pwm_duty_meter_sync_edge.sv
// Optional 2-flop synchronizer followed by a one-clock history flop.
// Produces the settled level and single-cycle rise/fall pulses.
module pwm_duty_meter_sync_edge #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);
    logic s;
    logic prev_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;

            // Two-stage metastability filter on the asynchronous pin.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q <= 2'b00;
                else        sync_q <= {sync_q[0], pin_i};
            end

            assign s = sync_q[1];
        end else begin : g_direct
            assign s = pin_i;
        end
    endgenerate

    // One-clock history of the settled level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= s;
    end

    assign s_o    = s;
    assign rise_o = s & ~prev_q;
    assign fall_o = ~s & prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and rising-to-rising period of pwm_in
// in clk cycles, one result per period, and flags a line with no rising
// edge for TIMEOUT clocks as stuck high or stuck low.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | after reset, counters at 0; first rise arms, timer expiry -> stuck
//  ST_MEAS  | armed, counting period/high; each rise publishes a result
//  ST_STUCK | no rise for TIMEOUT clocks; stuck flags follow the line level
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_duty_meter_if.master bus
);
    localparam int            TW       = tmr_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] PER_TMO  = CW'(TIMEOUT - 1);
    localparam logic [TW-1:0] IDLE_TMO = TW'(TIMEOUT - 1);

    logic s, rise, fall;

    meter_state_e  state_q;
    logic [TW-1:0] idle_tmr_q;
    logic [CW-1:0] per_c_q, hi_c_q;
    logic [CW-1:0] per_c_d, hi_c_d;
    logic          hi_frz_q;
    logic [CW-1:0] high_q, period_q;
    logic          meas_valid_q, stuck_high_q, stuck_low_q;

    pwm_duty_meter_sync_edge #(.SYNC_EN(SYNC_EN)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (bus.pwm_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Saturating increments; high time stops counting from the fall onward.
    assign per_c_d = (per_c_q == CNT_MAX) ? per_c_q : per_c_q + 1'b1;
    assign hi_c_d  = (hi_frz_q || fall || hi_c_q == CNT_MAX) ? hi_c_q : hi_c_q + 1'b1;

    // Measurement FSM with counters and registered outputs; a rise always
    // takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idle_tmr_q   <= IDLE_TMO;
            per_c_q      <= '0;
            hi_c_q       <= '0;
            hi_frz_q     <= 1'b0;
            high_q       <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q  <= ST_MEAS;
                        per_c_q  <= CW'(1);
                        hi_c_q   <= CW'(1);
                        hi_frz_q <= 1'b0;
                    end else if (idle_tmr_q == '0) begin
                        state_q      <= ST_STUCK;
                        stuck_high_q <= s;
                        stuck_low_q  <= ~s;
                    end else begin
                        idle_tmr_q <= idle_tmr_q - 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_q     <= per_c_q;
                        high_q       <= hi_c_q;
                        meas_valid_q <= 1'b1;
                        per_c_q      <= CW'(1);
                        hi_c_q       <= CW'(1);
                        hi_frz_q     <= 1'b0;
                        stuck_high_q <= 1'b0;
                        stuck_low_q  <= 1'b0;
                    end else if (per_c_q == PER_TMO) begin
                        state_q      <= ST_STUCK;
                        stuck_high_q <= s;
                        stuck_low_q  <= ~s;
                    end else begin
                        per_c_q <= per_c_d;
                        hi_c_q  <= hi_c_d;
                        if (fall) hi_frz_q <= 1'b1;
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        state_q      <= ST_MEAS;
                        per_c_q      <= CW'(1);
                        hi_c_q       <= CW'(1);
                        hi_frz_q     <= 1'b0;
                        stuck_high_q <= 1'b0;
                        stuck_low_q  <= 1'b0;
                    end else begin
                        stuck_high_q <= s;
                        stuck_low_q  <= ~s;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.high_cnt   = high_q;
    assign bus.period_cnt = period_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.stuck_high = stuck_high_q;
    assign bus.stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: one synchronized and one direct-drive instance
// share a bench-driven PWM line. A reference model works on the per-clock
// samples of the line and queues expected (high, period) results; a monitor
// pops and compares whenever an instance strobes meas_valid, and checks the
// stuck flags wherever the line history makes them unambiguous.
module tb_pwm_duty_meter;
    localparam int CW      = 16;
    localparam int TIMEOUT = 1024;
    localparam int MARGIN  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm   = 1'b0;

    typedef struct {
        int hi;
        int per;
    } meas_t;

    meas_t q0[$];
    meas_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit exp_def = 1'b0;
    bit exp_sh  = 1'b0;
    bit exp_sl  = 1'b0;

    pwm_duty_meter_if #(.CW(CW)) ifc0 ();
    pwm_duty_meter_if #(.CW(CW)) ifc1 ();

    assign ifc0.pwm_in = pwm;
    assign ifc1.pwm_in = pwm;

    pwm_duty_meter #(.CW(CW), .TIMEOUT(TIMEOUT), .SYNC_EN(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.master)
    );

    pwm_duty_meter #(.CW(CW), .TIMEOUT(TIMEOUT), .SYNC_EN(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: works purely on what the line looked like at each clock.
    initial begin : model
        bit        armed;
        bit        prev;
        bit        smp;
        int        cnt;
        int        hi;
        int        quiet;
        logic [4:0] hist;
        meas_t     m;
        armed = 1'b0; prev = 1'b0; cnt = 0; hi = 0; quiet = 0; hist = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                armed = 1'b0; prev = 1'b0; cnt = 0; hi = 0; quiet = 0; hist = '0;
                exp_def = 1'b0;
            end else begin
                smp  = pwm;
                hist = {hist[3:0], smp};
                if (smp && !prev) begin
                    if (armed) begin
                        m.hi  = hi;
                        m.per = cnt;
                        q0.push_back(m);
                        q1.push_back(m);
                    end
                    armed = 1'b1;
                    cnt   = 1;
                    hi    = 1;
                    quiet = 0;
                end else begin
                    quiet++;
                    if (armed) begin
                        cnt++;
                        hi += int'(smp);
                        if (cnt >= TIMEOUT) armed = 1'b0;
                    end
                end
                prev = smp;
                if (quiet >= TIMEOUT + MARGIN && (hist == 5'b11111 || hist == 5'b00000)) begin
                    exp_def = 1'b1;
                    exp_sh  = smp;
                    exp_sl  = ~smp;
                end else if (quiet >= MARGIN && quiet <= TIMEOUT - MARGIN) begin
                    exp_def = 1'b1;
                    exp_sh  = 1'b0;
                    exp_sl  = 1'b0;
                end else begin
                    exp_def = 1'b0;
                end
            end
        end
    end

    task automatic mon(input int d, input logic mv, input logic [CW-1:0] hc,
                       input logic [CW-1:0] pc, input logic sh, input logic sl);
        meas_t m;
        bit    empty;
        if (mv) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_checks++;
                $display("FAIL meas_unexpected dut%0d: got meas_valid=1 (high=%0d period=%0d), expected none",
                         d, hc, pc);
            end else begin
                if (d == 0) m = q0.pop_front();
                else        m = q1.pop_front();
                chk($sformatf("high_cnt dut%0d", d), int'(hc), m.hi);
                chk($sformatf("period_cnt dut%0d", d), int'(pc), m.per);
            end
        end
        if (exp_def) begin
            chk($sformatf("stuck_high dut%0d", d), int'(sh), int'(exp_sh));
            chk($sformatf("stuck_low dut%0d", d), int'(sl), int'(exp_sl));
        end
    endtask

    // Monitor: compares both instances away from the active edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon(0, ifc0.meas_valid, ifc0.high_cnt, ifc0.period_cnt, ifc0.stuck_high, ifc0.stuck_low);
                mon(1, ifc1.meas_valid, ifc1.high_cnt, ifc1.period_cnt, ifc1.stuck_high, ifc1.stuck_low);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_period(input int h, input int l);
        if (h > 0) begin pwm = 1'b1; cyc(h); end
        if (l > 0) begin pwm = 1'b0; cyc(l); end
    endtask

    task automatic chk_outs(input string tag, input int hc, input int pc,
                            input int mv, input int sh, input int sl);
        chk({tag, " high_cnt dut0"},   int'(ifc0.high_cnt),   hc);
        chk({tag, " period_cnt dut0"}, int'(ifc0.period_cnt), pc);
        chk({tag, " meas_valid dut0"}, int'(ifc0.meas_valid), mv);
        chk({tag, " stuck_high dut0"}, int'(ifc0.stuck_high), sh);
        chk({tag, " stuck_low dut0"},  int'(ifc0.stuck_low),  sl);
        chk({tag, " high_cnt dut1"},   int'(ifc1.high_cnt),   hc);
        chk({tag, " period_cnt dut1"}, int'(ifc1.period_cnt), pc);
        chk({tag, " meas_valid dut1"}, int'(ifc1.meas_valid), mv);
        chk({tag, " stuck_high dut1"}, int'(ifc1.stuck_high), sh);
        chk({tag, " stuck_low dut1"},  int'(ifc1.stuck_low),  sl);
    endtask

    // Stimulus
    initial begin : stim
        cyc(3);
        chk_outs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(5);

        // duty 10 of 256, then a change to 255 of 256
        repeat (6) pwm_period(10, 246);
        repeat (4) pwm_period(255, 1);

        // line held low: stuck_low, last result held
        pwm = 1'b0;
        cyc(TIMEOUT + 50);
        chk_outs("held_low", 255, 256, 0, 0, 1);

        // line high from reset: stuck_high
        pwm   = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(TIMEOUT + 50);
        chk_outs("held_high", 0, 0, 0, 1, 0);

        // release to duty 128
        pwm = 1'b0;
        cyc(128);
        pwm = 1'b1;
        cyc(10);
        chk_outs("after_rise", 0, 0, 0, 0, 0);
        cyc(118);
        pwm = 1'b0;
        cyc(128);
        repeat (3) pwm_period(128, 128);

        // reset pulse in the middle of a high phase
        pwm = 1'b1;
        cyc(50);
        rst_n = 1'b0;
        cyc(1);
        chk_outs("mid_reset", 0, 0, 0, 0, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(75);
        pwm = 1'b0;
        cyc(128);
        repeat (3) pwm_period(128, 128);

        // short patterns
        repeat (5) pwm_period(3, 5);
        repeat (5) pwm_period(1, 1);

        // random periods
        repeat (40) pwm_period(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)));

        // period TIMEOUT-1 is measured, period TIMEOUT is not
        pwm_period(5, TIMEOUT - 6);
        pwm_period(5, TIMEOUT - 5);
        repeat (3) pwm_period(20, 30);

        pwm = 1'b0;
        cyc(20);
        chk("pending results dut0", q0.size(), 0);
        chk("pending results dut1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a runaway run.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected stimulus to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
